// File: rtl/alu_req_pkg.sv
// Shared types and constants for the ALU requester: FSM state encoding,
// 4-bit ALU opcodes and the default result width.
package alu_req_pkg;

  localparam int RESULT_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1111;

endpackage

// File: rtl/alu_requester_if.sv
// Command and response channels between a client (master) and the ALU
// requester (slave).
interface alu_requester_if #(
  parameter int RESULT_W = alu_req_pkg::RESULT_W_DEF
);
  // Both channels are valid/ready: a beat transfers on a rising clock edge
  // where valid and ready are both 1; once raised, valid and its payload
  // stay stable until that edge.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_a;
  logic [1:0]          cmd_b;
  logic [3:0]          cmd_sel;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESULT_W-1:0] rsp_data;
  logic                rsp_carry;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_req_timer.sv
// Grant-wait counter: counts enabled cycles and flags the last allowed one.
module alu_req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      count <= '0;
    else if (clear)    count <= '0;
    else if (enable)   count <= count + 4'd1;
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/alu_requester.sv
// Captures an ALU command, arbitrates for a shared ALU and returns its result.
// Optional grant-wait timeout is enabled by defining ALU_REQ_TIMEOUT_EN.
module alu_requester
  import alu_req_pkg::*;
#(
  parameter int TIMEOUT  = 15,
  parameter int RESULT_W = RESULT_W_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  alu_requester_if.slave      bus,
  output logic                req,
  input  logic                gnt,
  output logic [1:0]          alu_a,
  output logic [1:0]          alu_b,
  output logic [3:0]          alu_sel,
  input  logic [RESULT_W-1:0] alu_out,
  input  logic                alu_carry,
  output state_e              dbg_state
);

  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
    $error("alu_requester: TIMEOUT must be in 1..15");
  end

  state_e              state;
  logic                expire;
  logic                rsp_valid_q;
  logic [RESULT_W-1:0] rsp_data_q;
  logic                rsp_carry_q;

  // A grant still held from the previous transaction blocks new commands.
  assign bus.cmd_ready = (state == ST_IDLE) && !gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign dbg_state     = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            alu_a   <= bus.cmd_a;
            alu_b   <= bus.cmd_b;
            alu_sel <= bus.cmd_sel;
            req     <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (gnt) begin
            state <= ST_EXEC;
          end else if (expire) begin
            req         <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_EXEC: begin
          req         <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= alu_out;
          rsp_carry_q <= alu_carry;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_REQ_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;
  logic err_q;

  assign timer_clear  = (state != ST_REQ) || gnt || expire;
  assign timer_enable = (state == ST_REQ) && !gnt;

  alu_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (expire)
  );

  // Error flag follows the path that leads into RESP and holds there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                  err_q <= 1'b0;
    else if ((state == ST_REQ) && !gnt && expire)  err_q <= 1'b1;
    else if (state == ST_EXEC)                     err_q <= 1'b0;
  end

  assign bus.rsp_err = err_q;
`else
  assign expire      = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_requester.sv
// Directed, table-driven bench for alu_requester with a behavioural ALU stub.
module tb_alu_requester;
  import alu_req_pkg::*;

  localparam int RW  = 7;
  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req;
  logic          gnt = 1'b0;
  logic [1:0]    alu_a, alu_b;
  logic [3:0]    alu_sel;
  logic [RW-1:0] alu_out;
  logic          alu_carry;
  state_e        dbg_state;

  always #5 clock = ~clock;

  alu_requester_if #(.RESULT_W(RW)) bus ();

  alu_requester #(.TIMEOUT(TMO), .RESULT_W(RW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .req      (req),
    .gnt      (gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_carry(alu_carry),
    .dbg_state(dbg_state)
  );

  // Behavioural ALU: {carry, data} from 8-bit arithmetic on zero-extended operands.
  function automatic logic [7:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                           input logic [3:0] sel);
    logic [7:0] ea, eb, r;
    ea = {6'b0, a};
    eb = {6'b0, b};
    case (sel)
      OP_ADD:  r = ea + eb;
      OP_SUB:  r = ea - eb;
      OP_MUL:  r = ea * eb;
      OP_AND:  r = ea & eb;
      OP_OR:   r = ea | eb;
      OP_XOR:  r = ea ^ eb;
      OP_EQ:   r = (a == b) ? 8'd1 : 8'd0;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  // ---------------- scoreboard ----------------
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]    a;
    logic [1:0]    b;
    logic [3:0]    sel;
    int            gnt_dly;
    logic [RW-1:0] exp_data;
    logic          exp_carry;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic accept_cmd(input logic [1:0] a, input logic [1:0] b, input logic [3:0] sel);
    int n;
    n = 0;
    @(negedge clock);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called at #1 after the accept edge; gnt rises d cycles after req.
  task automatic wait_rsp(input int d, input bit keep_gnt, output int lat, output int rc);
    lat = -1;
    rc  = req ? 1 : 0;
    if (d == 0) gnt = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == d) gnt = 1'b1;
      if (k == d + 1 && !keep_gnt) gnt = 1'b0;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      if (req) rc++;
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("state_after_rsp", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_vec(input vec_t v, input bit keep_gnt);
    int            lat, rc;
    logic [RW-1:0] exp_d;
    accept_cmd(v.a, v.b, v.sel);
    exp_q.push_back(v.exp_data);
    check("alu_a", 32'(alu_a), 32'(v.a));
    check("alu_b", 32'(alu_b), 32'(v.b));
    check("alu_sel", 32'(alu_sel), 32'(v.sel));
    wait_rsp(v.gnt_dly, keep_gnt, lat, rc);
    check("latency", 32'(lat), 32'(v.gnt_dly + 2));
    check("req_cycles", 32'(rc), 32'(v.gnt_dly + 2));
    exp_d = exp_q.pop_front();
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    check("rsp_carry", 32'(bus.rsp_carry), 32'(v.exp_carry));
    check("rsp_err", 32'(bus.rsp_err), 32'd0);
    release_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int            lat, rc;
    logic [RW-1:0] exp_d;

    vecs[0] = '{a: 2'd3, b: 2'd3, sel: OP_EQ,  gnt_dly: 1, exp_data: 7'd1,  exp_carry: 1'b0};
    vecs[1] = '{a: 2'd3, b: 2'd3, sel: OP_AND, gnt_dly: 0, exp_data: 7'd3,  exp_carry: 1'b0};
    vecs[2] = '{a: 2'd3, b: 2'd2, sel: OP_ADD, gnt_dly: 2, exp_data: 7'd5,  exp_carry: 1'b0};
    vecs[3] = '{a: 2'd1, b: 2'd2, sel: OP_SUB, gnt_dly: 1, exp_data: 7'h7f, exp_carry: 1'b1};
    vecs[4] = '{a: 2'd2, b: 2'd3, sel: OP_XOR, gnt_dly: 3, exp_data: 7'd1,  exp_carry: 1'b0};
    vecs[5] = '{a: 2'd0, b: 2'd0, sel: OP_EQ,  gnt_dly: 1, exp_data: 7'd1,  exp_carry: 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;

    // Reset values after a clock edge with reset held low.
    @(negedge clock);
    check("rst_req", 32'(req), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Command presented at release is accepted on the first edge after it.
    bus.cmd_a     = 2'd2;
    bus.cmd_b     = 2'd1;
    bus.cmd_sel   = OP_MUL;
    bus.cmd_valid = 1'b1;
    reset_n       = 1'b1;
    check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    exp_q.push_back(7'd2);
    check("first_accept_state", 32'(dbg_state), 32'(ST_REQ));
    check("first_accept_alu", 32'({alu_a, alu_b, alu_sel}), 32'({2'd2, 2'd1, OP_MUL}));
    wait_rsp(1, 1'b0, lat, rc);
    check("basic_latency", 32'(lat), 32'd3);
    exp_d = exp_q.pop_front();
    check("basic_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    check("basic_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    check("basic_rsp_err", 32'(bus.rsp_err), 32'd0);
    release_rsp();

    // Table vectors; 0 and 1 are back-to-back EQ then AND.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Response stall with a pending command; release edge must not accept it.
    accept_cmd(2'd3, 2'd2, OP_ADD);
    exp_q.push_back(7'd5);
    wait_rsp(1, 1'b0, lat, rc);
    exp_d = exp_q.pop_front();
    bus.cmd_a     = 2'd1;
    bus.cmd_b     = 2'd1;
    bus.cmd_sel   = OP_OR;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("stall_release_state", 32'(dbg_state), 32'(ST_IDLE));
    check("stall_no_capture", 32'({alu_a, alu_b, alu_sel}), 32'({2'd3, 2'd2, OP_ADD}));

    // Grant left high after a transaction blocks the next command until it falls.
    run_vec(vecs[5], 1'b1);
    bus.cmd_a     = 2'd2;
    bus.cmd_b     = 2'd2;
    bus.cmd_sel   = OP_ADD;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("gnt_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clock);
      #1;
      check("gnt_hold_state", 32'(dbg_state), 32'(ST_IDLE));
    end
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    gnt           = 1'b0;
    #1;
    check("gnt_fall_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    accept_cmd(2'd2, 2'd2, OP_ADD);
    wait_rsp(1, 1'b0, lat, rc);
    check("gnt_fall_latency", 32'(lat), 32'd3);
    check("gnt_fall_rsp_data", 32'(bus.rsp_data), 32'd4);
    release_rsp();

    // Asynchronous reset in EXEC drops the command.
    accept_cmd(2'd1, 2'd1, OP_ADD);
    @(posedge clock);
    #1;
    gnt = 1'b1;
    @(posedge clock);
    #1;
    gnt = 1'b0;
    check("pre_reset_state", 32'(dbg_state), 32'(ST_EXEC));
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(req), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (bus.rsp_valid) rc++;
    end
    check("no_rsp_after_rst", 32'(rc), 32'd0);

`ifdef ALU_REQ_TIMEOUT_EN
    // No grant: request held TMO cycles then an error response.
    accept_cmd(2'd2, 2'd2, OP_MUL);
    wait_rsp(100, 1'b0, lat, rc);
    check("timeout_latency", 32'(lat), 32'(TMO));
    check("timeout_req_cycles", 32'(rc), 32'(TMO));
    check("timeout_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("timeout_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("timeout_rsp_carry", 32'(bus.rsp_carry), 32'd0);
    release_rsp();
`else
    // No timeout: the request waits indefinitely for a grant.
    accept_cmd(2'd2, 2'd2, OP_MUL);
    repeat (20) @(posedge clock);
    #1;
    check("wait_req", 32'(req), 32'd1);
    check("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("wait_state", 32'(dbg_state), 32'(ST_REQ));
    wait_rsp(0, 1'b0, lat, rc);
    check("late_gnt_latency", 32'(lat), 32'd2);
    check("late_gnt_rsp_data", 32'(bus.rsp_data), 32'd4);
    check("late_gnt_rsp_err", 32'(bus.rsp_err), 32'd0);
    release_rsp();
`endif

    run_vec(vecs[2], 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
- REQ-001: Parameter TIMEOUT, default 15, grant-wait cycles before abort (range 1..15).
- REQ-002: Parameter RESULT_W, default 7, ALU result width.
- REQ-003: clock  input  1  single clock, all state updates on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: cmd_valid/cmd_ready  input/output  1/1  command handshake; transfer when both high at a clock edge.
- REQ-006: cmd_a, cmd_b  input  2 each  operands; cmd_sel  input  4  ALU opcode.
- REQ-007: req  output  1  arbiter request; gnt  input  1  arbiter grant.
- REQ-008: alu_a, alu_b  output  2 each; alu_sel  output  4  registered operands/opcode to ALU.
- REQ-009: alu_out  input  RESULT_W; alu_carry  input  1  combinational ALU result.
- REQ-010: rsp_valid/rsp_ready  output/input  1/1  response handshake.
- REQ-011: rsp_data  output  RESULT_W; rsp_carry  output  1; rsp_err  output  1  timeout flag.

Function
- REQ-012: The FSM SHALL have states IDLE, REQ, EXEC, RESP, one-hot or binary encoded.
- REQ-013: IDLE: cmd_ready SHALL equal ~gnt; on transfer, cmd_a/cmd_b/cmd_sel SHALL be captured into alu_a/alu_b/alu_sel and state SHALL go to REQ.
- REQ-014: REQ: req SHALL be 1; gnt sampled 1 SHALL move to EXEC and clear the wait counter.
- REQ-015: REQ: each cycle without gnt SHALL increment the wait counter; at count TIMEOUT-1 without gnt the block SHALL set rsp_err=1, rsp_data=0, rsp_carry=0 and go to RESP.
- REQ-016: EXEC: req SHALL stay 1 for exactly one cycle; at its end alu_out/alu_carry SHALL be registered into rsp_data/rsp_carry, rsp_err=0, state to RESP.
- REQ-017: RESP: req SHALL be 0; rsp_valid SHALL be 1 and rsp_data/rsp_carry/rsp_err stable until rsp_ready is sampled 1, then state to IDLE.
- REQ-018: With gnt arriving one cycle after req, accept at edge N SHALL give rsp_valid high after edge N+3.
- REQ-019: gnt high in IDLE, EXEC-exit or RESP SHALL be ignored; cmd_ready SHALL stay 0 in REQ, EXEC, RESP.
- REQ-020: alu_a/alu_b/alu_sel SHALL hold captured values from accept until the next accept.
- REQ-021: cmd_valid and rsp_ready simultaneous in RESP SHALL not accept the command that cycle.

Reset
- REQ-022: reset_n low SHALL force state IDLE, req=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0, alu_a=alu_b=0, alu_sel=0, wait counter 0, immediately and asynchronously.
- REQ-023: reset mid-transaction SHALL drop the in-flight command with no response.
- REQ-024: reset deassertion SHALL be consumed synchronously; first accept possible on the first edge after release.

Configuration
- REQ-025: Macro ALU_REQ_TIMEOUT_EN defined: REQ-015 active, rsp_err reports timeouts.
- REQ-026: ALU_REQ_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for gnt; rsp_err tied to 0.

Structure
- REQ-027: Package alu_req_pkg SHALL hold the state typedef, 4-bit opcode constants (ADD=0000 .. EQ=1111), and RESULT_W default.
- REQ-028: The wait counter SHALL be a sub-module alu_req_timer (clear, enable, expire output), instantiated only under ALU_REQ_TIMEOUT_EN.

Verification
- REQ-029: cmd a=2,b=1,sel=0010, gnt one cycle after req, alu_out=2 -> rsp_data=2, rsp_carry=0, rsp_err=0, rsp_valid after accept+3.
- REQ-030: gnt never asserted, TIMEOUT=4 -> req high 4 cycles, rsp_valid with rsp_err=1, rsp_data=0.
- REQ-031: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable 5 cycles, no new cmd_ready.
- REQ-032: reset_n pulsed low during EXEC -> req=0, rsp_valid=0 immediately; state IDLE.
- REQ-033: gnt still high in IDLE after previous transaction -> cmd_ready=0 until gnt falls.
- REQ-034: back-to-back cmds a=3,b=3,sel=1111 then sel=1000 -> rsp_data 1 then 3, in order.
